// File: rtl/polynomial3_scheduler.sv
// Round-robin shared evaluator for y = a*x^2 + b*x + c across NUM_REQ requesters.
// One 35x10 multiplier is reused over two Horner steps; the result is returned with the requester tag.
module polynomial3_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*24-1:0] req_a,
   input  logic [NUM_REQ*24-1:0] req_b,
   input  logic [NUM_REQ*32-1:0] req_c,
   input  logic [NUM_REQ*10-1:0] req_x,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ID_W-1:0]       resp_id,
   output logic [45:0]           resp_y,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, MUL1, MUL2, RESP} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] win_id, cand;
   logic            win_found;
   logic            accept;
   logic [23:0]     a_q, b_q;
   logic [31:0]     c_q;
   logic [9:0]      x_q;
   logic [45:0]     acc_q, acc_d;
   logic [34:0]     mul_op;
   logic [44:0]     prod;

   // Round-robin search starting at ptr_q
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign accept = (state_q == IDLE) && win_found;

   always_comb begin
      req_ready = '0;
      if (accept && !rst) req_ready[win_id] = 1'b1;
   end

   // Single shared multiplier: a*x in MUL1, acc*x in MUL2
   assign mul_op = (state_q == MUL2) ? acc_q[34:0] : {11'd0, a_q};
   assign prod   = 45'(mul_op) * 45'(x_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MUL1;
               ptr_d   = ID_W'((int'(win_id) + 1) % NUM_REQ);
            end
         end
         MUL1: begin
            acc_d   = 46'(prod) + 46'(b_q);
            state_d = MUL2;
         end
         MUL2: begin
            acc_d   = 46'(prod) + 46'(c_q);
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         acc_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         acc_q   <= acc_d;
         if (accept) id_q <= win_id;
      end
   end

   // Operands are captured only at the accept edge
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= req_a[int'(win_id)*24 +: 24];
         b_q <= req_b[int'(win_id)*24 +: 24];
         c_q <= req_c[int'(win_id)*32 +: 32];
         x_q <= req_x[int'(win_id)*10 +: 10];
      end
   end

   assign resp_valid = (state_q == RESP);
   assign resp_y     = acc_q;
   assign resp_id    = id_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_polynomial3_scheduler.sv
// Randomized + directed bench for polynomial3_scheduler against a transaction-level reference model.
module tb_polynomial3_scheduler;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*24-1:0] req_a, req_b;
   logic [N*32-1:0] req_c;
   logic [N*10-1:0] req_x;
   logic            resp_valid, resp_ready;
   logic [IW-1:0]   resp_id;
   logic [45:0]     resp_y;
   logic            busy;

   always #5 clk = ~clk;

   polynomial3_scheduler #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_x(req_x),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_y(resp_y), .busy(busy)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint unsigned poly(longint unsigned a, longint unsigned b,
                                            longint unsigned c, longint unsigned x);
      return a * x * x + b * x + c;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: tracks the in-flight transaction as "cycles since accept"
   int mcnt = 0, mptr = 0, mid = 0;
   longint unsigned my = 0;
   bit post_rst = 0, prev_rv = 0, last_acc = 0;
   int last_acc_id = 0;
   int acc_ids[$], acc_cycs[$], rsp_ids[$], rise_cycs[$];
   longint unsigned rsp_ys[$];

   always @(negedge clk) begin
      logic [N-1:0] er;
      int w;
      er = '0;
      w = -1;
      last_acc = 0;
      if (resp_valid === 1'b1 && !prev_rv) rise_cycs.push_back(cyc);
      prev_rv = (resp_valid === 1'b1);
      if (rst) begin
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_resp_y", resp_y, 0);
         chk("rst_resp_id", resp_id, 0);
         mcnt = 0;
         mptr = 0;
         post_rst = 1;
      end else begin
         if (mcnt == 0)
            for (int k = 0; k < N; k++)
               if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
         if (w >= 0) er[w] = 1'b1;
         chk("req_ready", req_ready, er);
         chk("busy", busy, mcnt != 0);
         chk("resp_valid", resp_valid, mcnt == 3);
         if (post_rst && mcnt == 0) begin
            chk("idle_after_rst_y", resp_y, 0);
            chk("idle_after_rst_id", resp_id, 0);
         end
         if (mcnt == 3) begin
            chk("resp_y", resp_y, my);
            chk("resp_id", resp_id, mid);
            if (resp_ready) begin
               rsp_ids.push_back(mid);
               rsp_ys.push_back(my);
               mcnt = 0;
            end
         end else if (mcnt != 0) begin
            mcnt++;
         end else if (w >= 0) begin
            my = poly(req_a[24*w +: 24], req_b[24*w +: 24], req_c[32*w +: 32], req_x[10*w +: 10]);
            mid = w;
            mptr = (w + 1) % N;
            mcnt = 1;
            post_rst = 0;
            acc_ids.push_back(w);
            acc_cycs.push_back(cyc);
            last_acc = 1;
            last_acc_id = w;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int i, logic [23:0] a, logic [23:0] b, logic [31:0] c, logic [9:0] x);
      req_a[24*i +: 24] = a;
      req_b[24*i +: 24] = b;
      req_c[32*i +: 32] = c;
      req_x[10*i +: 10] = x;
      req_valid[i] = 1'b1;
   endtask

   task automatic set_rand(int i);
      logic [23:0] a, b;
      logic [31:0] c;
      a = ($urandom % 8 == 0) ? 24'hFFFFFF : 24'($urandom);
      b = ($urandom % 8 == 0) ? 24'hFFFFFF : 24'($urandom);
      c = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
      set_req(i, a, b, c, 10'($urandom_range(0, 1023)));
   endtask

   task automatic wait_acc(int i);
      bit ok;
      ok = 0;
      for (int t = 0; t < 60 && !ok; t++) begin
         tick();
         if (last_acc && last_acc_id == i) ok = 1;
      end
      chk("accept_seen", ok, 1);
   endtask

   task automatic wait_resp(int n_before);
      for (int t = 0; t < 60 && rsp_ids.size() <= n_before; t++) tick();
      chk("response_seen", rsp_ids.size() > n_before, 1);
   endtask

   task automatic drain();
      req_valid = '0;
      resp_ready = 1'b1;
      for (int t = 0; t < 40 && mcnt != 0; t++) tick();
      tick();
      chk("drained", mcnt, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n, na;
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      req_c = '0;
      req_x = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("model_228", poly(42, 184, 2, 1), 228);
      chk("model_932", poly(42, 184, 2, 3), 932);
      chk("model_max", poly(24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFFFF, 1023), 64'd17579300094975);

      // Single request, latency
      resp_ready = 1'b1;
      n = rsp_ids.size();
      set_req(0, 42, 184, 2, 1);
      wait_acc(0);
      req_valid[0] = 1'b0;
      wait_resp(n);
      if (rsp_ids.size() > n) begin
         chk("t1_y", rsp_ys[n], 228);
         chk("t1_id", rsp_ids[n], 0);
         chk("t1_latency", rise_cycs[rise_cycs.size()-1] - acc_cycs[acc_cycs.size()-1], 3);
      end

      // Backpressure hold
      resp_ready = 1'b0;
      set_req(2, 42, 184, 2, 3);
      wait_acc(2);
      req_valid[2] = 1'b0;
      for (int t = 0; t < 20 && resp_valid !== 1'b1; t++) tick();
      set_rand(0);
      repeat (5) begin
         tick();
         chk("t2_y", resp_y, 932);
         chk("t2_id", resp_id, 2);
         chk("t2_ready", req_ready, 0);
         chk("t2_busy", busy, 1);
      end
      resp_ready = 1'b1;
      wait_acc(0);
      drain();

      // Max operands
      n = rsp_ids.size();
      set_req(3, 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFFFF, 10'd1023);
      wait_acc(3);
      req_valid[3] = 1'b0;
      wait_resp(n);
      if (rsp_ids.size() > n) chk("t3_max_y", rsp_ys[n], 64'd17579300094975);
      drain();

      // All requesters continuously valid after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 24'(1000 + i), 24'(77 * i), 32'(i), 10'(100 * i + 7));
      na = acc_ids.size();
      for (int t = 0; t < 60 && acc_ids.size() < na + 5; t++) tick();
      chk("t4_five_accepts", acc_ids.size() >= na + 5, 1);
      if (acc_ids.size() >= na + 5) begin
         for (int j = 0; j < 5; j++) chk("t4_order", acc_ids[na+j], j % 4);
         for (int j = 1; j < 5; j++) chk("t4_spacing", acc_cycs[na+j] - acc_cycs[na+j-1], 4);
      end
      drain();

      // Reset during MUL2 drops the request; pointer restarts at 0
      set_req(1, 11, 22, 33, 44);
      wait_acc(1);
      req_valid[1] = 1'b0;
      tick();
      rst = 1'b1;
      n = rsp_ids.size();
      tick();
      rst = 1'b0;
      repeat (8) tick();
      chk("t5_no_resp", rsp_ids.size(), n);
      na = acc_ids.size();
      set_req(1, 5, 6, 7, 8);
      set_req(3, 9, 10, 11, 12);
      wait_acc(1);
      req_valid[1] = 1'b0;
      if (acc_ids.size() > na) chk("t5_first_grant", acc_ids[na], 1);
      wait_acc(3);
      req_valid[3] = 1'b0;
      drain();

      // Inputs changed after accept must not affect the result
      n = rsp_ids.size();
      set_req(0, 5, 7, 9, 11);
      wait_acc(0);
      req_a[23:0] = 24'hABCDEF;
      req_x[9:0] = 10'd1000;
      req_valid[0] = 1'b0;
      wait_resp(n);
      if (rsp_ids.size() > n) chk("t6_y", rsp_ys[n], 691);
      drain();

      // Randomized traffic with random backpressure
      repeat (1500) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (last_acc && last_acc_id == i) begin
               if ($urandom % 2 == 0) set_rand(i);
               else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom % 3 == 0) begin
               set_rand(i);
            end
         end
         resp_ready = ($urandom % 4) != 0;
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
